// File: rtl/sae_pkg.sv
// Shared types for the sae host sequencer: core modes, core error flags
// and the host FSM state encoding.
package sae_pkg;

  typedef enum logic [1:0] {
    MODE_ENC = 2'b01,
    MODE_DEC = 2'b10
  } mode_t;

  typedef struct packed {
    logic ctxt;
    logic seckey;
    logic ptxt;
  } sae_err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELIVER
  } host_state_t;

endpackage

// File: rtl/sae_host_timer.sv
// Response watchdog: loaded on every issue, counts down while the host waits,
// and flags expiry once TIMEOUT wait cycles have elapsed without a response.
module sae_host_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count_reg;

  // Loading TIMEOUT-1 makes the TIMEOUT-th wait cycle the one where count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= W'(TIMEOUT - 1);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/sae_host.sv
// Host-side sequencer for the sae cipher core: feeds one character at a time
// from a framed input stream and returns the core's answers as a framed stream.
module sae_host #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_key,
  input  logic [7:0]       in_char,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [1:0]       sae_mode,
  output logic [7:0]       sae_data_input,
  output logic [7:0]       sae_key_input,
  output logic             sae_inputs_valid,
  input  logic [7:0]       sae_data_output,
  input  logic             sae_output_ready,
  input  logic [2:0]       sae_err,
  output logic [7:0]       out_char,
  output logic [2:0]       out_err,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] char_count
);

  import sae_pkg::*;

  host_state_t state_reg, state_next;

  logic start_accept, issue, capture, timeout_hit, timer_en, timer_expired;

  logic [1:0]       mode_reg;
  logic [7:0]       key_reg, data_reg, out_char_reg;
  sae_err_t         out_err_reg;
  logic             last_reg, inputs_valid_reg, timeout_err_reg;
  logic [CNT_W-1:0] char_count_reg;

  sae_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (issue),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    start_accept = 1'b0;
    issue        = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    timer_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          start_accept = 1'b1;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          issue      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        // A response on the expiry cycle wins over the timeout.
        if (sae_output_ready) begin
          capture    = 1'b1;
          state_next = ST_DELIVER;
        end else if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        out_valid = 1'b1;
        if (out_ready) state_next = last_reg ? ST_IDLE : ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg         <= '0;
      key_reg          <= '0;
      data_reg         <= '0;
      last_reg         <= 1'b0;
      inputs_valid_reg <= 1'b0;
      out_char_reg     <= '0;
      out_err_reg      <= '0;
      timeout_err_reg  <= 1'b0;
      char_count_reg   <= '0;
    end else begin
      inputs_valid_reg <= issue;
      if (start_accept) begin
        mode_reg        <= cfg_mode;
        key_reg         <= cfg_key;
        char_count_reg  <= '0;
        timeout_err_reg <= 1'b0;
      end
      if (issue) begin
        data_reg <= in_char;
        last_reg <= in_last;
      end
      if (capture) begin
        out_char_reg   <= sae_data_output;
        out_err_reg    <= sae_err;
        char_count_reg <= char_count_reg + CNT_W'(1);
      end
      if (timeout_hit) timeout_err_reg <= 1'b1;
    end
  end

  assign sae_mode         = mode_reg;
  assign sae_key_input    = key_reg;
  assign sae_data_input   = data_reg;
  assign sae_inputs_valid = inputs_valid_reg;
  assign out_char         = out_char_reg;
  assign out_err          = out_err_reg;
  assign out_last         = last_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign timeout_err      = timeout_err_reg;
  assign char_count       = char_count_reg;

endmodule

// File: tb/tb_sae_host.sv
// Self-checking bench for sae_host with a behavioural sae core stub that answers
// after a programmable latency; results are checked against a frame-level model.
module tb_sae_host;

  localparam logic [1:0] ENC = 2'b01;
  localparam logic [1:0] DEC = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_key = '0;
  logic [7:0] in_char = '0;
  logic       in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [1:0] sae_mode;
  logic [7:0] sae_data_input, sae_key_input;
  logic       sae_inputs_valid;
  logic [7:0] sae_data_output = '0;
  logic       sae_output_ready = 1'b0;
  logic [2:0] sae_err = '0;
  logic [7:0] out_char;
  logic [2:0] out_err;
  logic       out_last, out_valid;
  logic       out_ready = 1'b0;
  logic       busy, timeout_err;
  logic [1:0] char_count;

  int checks = 0, failures = 0;

  sae_host #(.TIMEOUT(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .in_char(in_char), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sae_mode(sae_mode), .sae_data_input(sae_data_input), .sae_key_input(sae_key_input),
    .sae_inputs_valid(sae_inputs_valid), .sae_data_output(sae_data_output),
    .sae_output_ready(sae_output_ready), .sae_err(sae_err),
    .out_char(out_char), .out_err(out_err), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err), .char_count(char_count)
  );

  always #5 clk = ~clk;

  // Behaviour of the cipher core as seen by the host.
  function automatic logic [7:0] core_ref(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
    if (m == ENC) return d + k;
    else if (m == DEC) return d - k;
    else return d;
  endfunction

  // Core stub: answers stub_lat wait cycles after the issue cycle, one-cycle pulse.
  int stub_cnt = 0, stub_lat = 3, stub_resp = 0, stub_err_at = -1, iv_count = 0;
  bit stub_on = 1'b1;
  always @(negedge clk) begin
    sae_output_ready = 1'b0;
    sae_err = 3'b000;
    if (sae_inputs_valid) iv_count++;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        sae_output_ready = 1'b1;
        sae_data_output = core_ref(sae_mode, sae_data_input, sae_key_input);
        sae_err = (stub_resp == stub_err_at) ? 3'b001 : 3'b000;
        stub_resp++;
      end
    end
    if (sae_inputs_valid && stub_on) stub_cnt = stub_lat;
  end

  logic [7:0] f_chars [0:15];
  logic [7:0] got_char [0:15];
  logic [2:0] got_err [0:15];
  logic       got_last [0:15];
  int         got_lat [0:15];
  int         got_n;

  task automatic do_reset();
    rst = 1'b1; cfg_start = 0; in_valid = 0; in_last = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [7:0] k);
    @(negedge clk);
    cfg_mode = m; cfg_key = k; cfg_start = 1'b1; stub_resp = 0;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] c, input logic last, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_wait got=%b want=1", in_ready);
      return;
    end
    in_char = c; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; ok = 1'b1;
  endtask

  task automatic wait_out_valid(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_wait got=%b want=1", out_valid);
      return;
    end
    ok = 1'b1;
  endtask

  task automatic xfer_char(input logic [7:0] c, input logic last, input int hold,
                           output logic [7:0] oc, output logic [2:0] oe, output logic ol,
                           output int lat, output bit ok);
    oc = '0; oe = '0; ol = 1'b0; lat = 0;
    push_char(c, last, ok);
    if (!ok) return;
    wait_out_valid(lat, ok);
    if (!ok) return;
    oc = out_char; oe = out_err; ol = out_last;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] k, input int n, input int hold);
    bit ok;
    start_frame(m, k);
    got_n = 0;
    for (int i = 0; i < n; i++) begin
      xfer_char(f_chars[i], (i == n - 1), hold, got_char[i], got_err[i], got_last[i], got_lat[i], ok);
      if (!ok) break;
      got_n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sae_mode, sae_data_input, sae_key_input, sae_inputs_valid} !== 19'd0) begin
      failures++; $display("FAIL reset_sae got=%h want=0", {sae_mode, sae_data_input, sae_key_input, sae_inputs_valid});
    end
    checks++;
    if ({out_char, out_err, out_last, out_valid} !== 13'd0) begin
      failures++; $display("FAIL reset_out got=%h want=0", {out_char, out_err, out_last, out_valid});
    end
    checks++;
    if ({in_ready, busy, timeout_err, char_count} !== 5'd0) begin
      failures++; $display("FAIL reset_ctl got=%h want=0", {in_ready, busy, timeout_err, char_count});
    end
  endtask

  task automatic test_basic_encrypt();
    int iv0;
    stub_on = 1; stub_lat = 3; stub_err_at = -1;
    f_chars[0] = "A"; f_chars[1] = "B"; f_chars[2] = "C";
    iv0 = iv_count;
    run_frame(ENC, 8'h03, 3, 0);
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_char[i] !== core_ref(ENC, f_chars[i], 8'h03)) begin
        failures++; $display("FAIL basic_char[%0d] got=%h want=%h", i, got_char[i], core_ref(ENC, f_chars[i], 8'h03));
      end
      checks++;
      if (got_last[i] !== (i == 2)) begin
        failures++; $display("FAIL basic_last[%0d] got=%b want=%b", i, got_last[i], (i == 2));
      end
    end
    checks++;
    if (got_lat[0] !== stub_lat + 1) begin
      failures++; $display("FAIL basic_latency got=%0d want=%0d", got_lat[0], stub_lat + 1);
    end
    checks++;
    if (char_count !== 2'd3) begin failures++; $display("FAIL basic_count got=%0d want=3", char_count); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b want=0", busy); end
    checks++;
    if (iv_count - iv0 !== 3) begin failures++; $display("FAIL basic_pulses got=%0d want=3", iv_count - iv0); end
    $display("basic_encrypt: chars=%0d count=%0d", got_n, char_count);
  endtask

  task automatic test_backpressure();
    bit ok; int lat, ivb;
    logic [7:0] k, c0, c1, oc;
    k = 8'($urandom); c0 = 8'($urandom); c1 = 8'($urandom);
    stub_lat = 2;
    start_frame(ENC, k);
    push_char(c0, 1'b0, ok);
    if (ok) wait_out_valid(lat, ok);
    if (ok) begin
      oc = out_char; ivb = iv_count;
      checks++;
      if (oc !== core_ref(ENC, c0, k)) begin failures++; $display("FAIL bp_char got=%h want=%h", oc, core_ref(ENC, c0, k)); end
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++;
        if (out_char !== oc || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          failures++; $display("FAIL bp_hold[%0d] got=%h/%b/%b want=%h/1/0", i, out_char, out_valid, in_ready, oc);
        end
      end
      checks++;
      if (iv_count !== ivb) begin failures++; $display("FAIL bp_pulses got=%0d want=%0d", iv_count, ivb); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
      xfer_char(c1, 1'b1, 0, got_char[0], got_err[0], got_last[0], got_lat[0], ok);
      checks++;
      if (got_char[0] !== core_ref(ENC, c1, k) || busy !== 1'b0) begin
        failures++; $display("FAIL bp_second got=%h busy=%b want=%h busy=0", got_char[0], busy, core_ref(ENC, c1, k));
      end
    end
    $display("backpressure: held=%h", oc);
  endtask

  task automatic test_timeout();
    bit ok, ov_seen;
    logic [7:0] k2, c;
    k2 = 8'($urandom); c = 8'($urandom);
    stub_on = 0;
    start_frame(ENC, 8'h11);
    push_char(8'h20, 1'b1, ok);
    ov_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
      if (i == 7) begin
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early got=%b want=0", timeout_err); end
      end
    end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag got=%b want=1", timeout_err); end
    checks++;
    if (busy !== 1'b0 || ov_seen) begin failures++; $display("FAIL to_idle busy=%b out_valid_seen=%b want=0/0", busy, ov_seen); end
    stub_on = 1; stub_lat = 3;
    start_frame(DEC, k2);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL to_clear got=%b busy=%b want=0 busy=1", timeout_err, busy);
    end
    xfer_char(c, 1'b1, 1, got_char[0], got_err[0], got_last[0], got_lat[0], ok);
    checks++;
    if (got_char[0] !== core_ref(DEC, c, k2) || char_count !== 2'd1) begin
      failures++; $display("FAIL to_next got=%h cnt=%0d want=%h cnt=1", got_char[0], char_count, core_ref(DEC, c, k2));
    end
    $display("timeout: flag_seen=%b", 1'b1);
  endtask

  task automatic test_err_passthrough();
    logic [7:0] k;
    k = 8'($urandom);
    for (int i = 0; i < 3; i++) f_chars[i] = 8'($urandom);
    stub_lat = $urandom_range(1, 5); stub_err_at = 1;
    run_frame(ENC, k, 3, 0);
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got_err[i] !== ((i == 1) ? 3'b001 : 3'b000) || got_char[i] !== core_ref(ENC, f_chars[i], k)) begin
        failures++; $display("FAIL err_pass[%0d] got=%b/%h want=%b/%h", i, got_err[i], got_char[i],
                             (i == 1) ? 3'b001 : 3'b000, core_ref(ENC, f_chars[i], k));
      end
    end
    checks++;
    if (busy !== 1'b0 || char_count !== 2'd3) begin
      failures++; $display("FAIL err_done busy=%b cnt=%0d want=0/3", busy, char_count);
    end
    stub_err_at = -1;
    $display("err_passthrough: chars=%0d", got_n);
  endtask

  task automatic test_reset_mid_wait();
    bit ok, bad;
    stub_lat = 5;
    start_frame(ENC, 8'h5a);
    push_char(8'h33, 1'b0, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++;
    if ({sae_mode, sae_data_input, sae_key_input, sae_inputs_valid} !== 19'd0 ||
        {out_char, out_err, out_last, out_valid} !== 13'd0 ||
        {in_ready, busy, timeout_err, char_count} !== 5'd0) begin
      failures++; $display("FAIL rst_wait_outputs got=%h/%h/%h want=0/0/0",
        {sae_mode, sae_data_input, sae_key_input, sae_inputs_valid},
        {out_char, out_err, out_last, out_valid}, {in_ready, busy, timeout_err, char_count});
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || char_count !== 2'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL rst_late_resp got=1 want=0 (late response acted on)"); end
    $display("reset_mid_wait: ignored_late=%b", !bad);
  endtask

  task automatic test_boundary();
    bit ok, ov_seen;
    int lat;
    logic [7:0] k1, c;
    // Response exactly on the last wait cycle.
    stub_lat = 7; k1 = 8'($urandom); f_chars[0] = 8'($urandom);
    run_frame(ENC, k1, 1, 0);
    checks++;
    if (got_n !== 1 || got_char[0] !== core_ref(ENC, f_chars[0], k1) || timeout_err !== 1'b0) begin
      failures++; $display("FAIL edge_accept got=%0d/%h/%b want=1/%h/0", got_n, got_char[0], timeout_err,
                           core_ref(ENC, f_chars[0], k1));
    end
    // One cycle later is a timeout; the late response is ignored.
    stub_lat = 8;
    start_frame(ENC, k1);
    push_char(8'h41, 1'b1, ok);
    ov_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (out_valid) ov_seen = 1'b1; end
    checks++;
    if (timeout_err !== 1'b1 || ov_seen || busy !== 1'b0) begin
      failures++; $display("FAIL edge_timeout got=%b/%b/%b want=1/0/0", timeout_err, ov_seen, busy);
    end
    // cfg_start while busy must not change the frame.
    stub_lat = 3; c = 8'($urandom);
    start_frame(ENC, k1);
    @(negedge clk); cfg_mode = DEC; cfg_key = ~k1; cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    push_char(c, 1'b1, ok);
    cfg_start = 1'b1; @(negedge clk); cfg_start = 1'b0;
    checks++;
    if (sae_mode !== ENC || sae_key_input !== k1) begin
      failures++; $display("FAIL busy_start got=%b/%h want=%b/%h", sae_mode, sae_key_input, ENC, k1);
    end
    wait_out_valid(lat, ok);
    checks++;
    if (out_char !== core_ref(ENC, c, k1)) begin
      failures++; $display("FAIL busy_start_char got=%h want=%h", out_char, core_ref(ENC, c, k1));
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    // Counter wraps modulo 4.
    for (int i = 0; i < 5; i++) f_chars[i] = 8'($urandom);
    stub_lat = 1;
    run_frame(DEC, k1, 5, 0);
    checks++;
    if (char_count !== 2'd1 || got_n !== 5) begin
      failures++; $display("FAIL count_wrap got=%0d/%0d want=1/5", char_count, got_n);
    end
    $display("boundary: wrap_count=%0d", char_count);
  endtask

  task automatic test_random_frames();
    logic [1:0] m; logic [7:0] k; int n, hold;
    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(0, 3))
        0: m = ENC;
        1: m = DEC;
        2: m = ENC;
        default: m = 2'b11;
      endcase
      k = 8'($urandom); n = $urandom_range(1, 6); hold = $urandom_range(0, 3);
      stub_lat = $urandom_range(1, 7);
      stub_err_at = $urandom_range(0, 7) - 1;
      for (int i = 0; i < n; i++) f_chars[i] = 8'($urandom);
      run_frame(m, k, n, hold);
      for (int i = 0; i < got_n; i++) begin
        checks++;
        if (got_char[i] !== core_ref(m, f_chars[i], k) ||
            got_err[i] !== ((i == stub_err_at) ? 3'b001 : 3'b000) ||
            got_last[i] !== (i == n - 1)) begin
          failures++; $display("FAIL rand[%0d][%0d] got=%h/%b/%b want=%h/%b/%b", f, i, got_char[i], got_err[i],
            got_last[i], core_ref(m, f_chars[i], k), (i == stub_err_at) ? 3'b001 : 3'b000, (i == n - 1));
        end
      end
      checks++;
      if (char_count !== 2'(n) || busy !== 1'b0 || got_n !== n) begin
        failures++; $display("FAIL rand_frame[%0d] got=%0d/%b/%0d want=%0d/0/%0d", f, char_count, busy, got_n, 2'(n), n);
      end
      $display("random frame %0d: mode=%b key=%h n=%0d lat=%0d", f, m, k, n, stub_lat);
    end
    stub_err_at = -1;
  endtask

  initial begin
    test_reset();
    test_basic_encrypt();
    test_backpressure();
    test_timeout();
    test_err_passthrough();
    test_reset_mid_wait();
    test_boundary();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation watchdog");
  end

endmodule
